// File: rtl/sa_autosa_bdma_rd_lat_fifo.sv
// rtl/sa_autosa_bdma_rd_lat_fifo.sv - BDMA read-return latency FIFO with credit-gated request forwarding
// Optional feature macro: SA_AUTOSA_RD_LAT_FIFO_OVF_CHECK_EN (drop writes into a full FIFO, flag rsp_ovf)
module sa_autosa_bdma_rd_lat_fifo #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int CW    = 6
) (
  input  logic           autosa_core_clk,
  input  logic           autosa_core_rstn,
  input  logic           bdma2mcif_rd_req_valid,
  output logic           bdma2mcif_rd_req_ready,
  input  logic [78:0]    bdma2mcif_rd_req_pd,
  output logic           mem_rd_req_valid,
  input  logic           mem_rd_req_ready,
  output logic [78:0]    mem_rd_req_pd,
  input  logic           mem_rd_rsp_valid,
  input  logic [513:0]   mem_rd_rsp_pd,
  output logic           mcif2bdma_rd_rsp_valid,
  input  logic           mcif2bdma_rd_rsp_ready,
  output logic [513:0]   mcif2bdma_rd_rsp_pd,
  input  logic           bdma2mcif_rd_cdt_lat_fifo_pop,
  output logic [CW-1:0]  cdt_avail,
  output logic           rd_idle,
  output logic           size_err,
  output logic           rsp_ovf
);

  localparam logic [15:0]   DEPTH16  = 16'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Credit accounting and request gating
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cdt_used;
  logic [CW-1:0] cdt_used_nxt;
  logic [15:0]   req_need;
  logic [15:0]   cdt_free;
  logic          req_fit;
  logic          req_acc;
  logic          pop_eff;

  // Atom count of the request; 16 bits so size=0x7fff cannot wrap to zero
  assign req_need = {1'b0, bdma2mcif_rd_req_pd[78:64]} + 16'd1;
  assign cdt_free = DEPTH16 - {{(16-CW){1'b0}}, cdt_used};
  assign req_fit  = (req_need <= cdt_free);

  assign mem_rd_req_valid       = bdma2mcif_rd_req_valid & req_fit;
  assign bdma2mcif_rd_req_ready = mem_rd_req_ready & req_fit;
  assign mem_rd_req_pd          = bdma2mcif_rd_req_pd;

  assign req_acc = bdma2mcif_rd_req_valid & bdma2mcif_rd_req_ready;
  // A pop with nothing outstanding is ignored so the counter never underflows
  assign pop_eff = bdma2mcif_rd_cdt_lat_fifo_pop & (cdt_used != '0);

  // Next credit count; an accepted need never exceeds the free credits, so CW bits suffice
  always_comb begin
    cdt_used_nxt = cdt_used
                 + (req_acc ? req_need[CW-1:0] : {CW{1'b0}})
                 - {{(CW-1){1'b0}}, pop_eff};
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic [513:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic [AW:0]  wp_nxt;
  logic [AW:0]  rp_nxt;
  logic         fifo_empty;
  logic         fifo_full;
  logic         fifo_empty_nxt;
  logic         rsp_rd;
  logic         rsp_wr;
  logic         rp_step;

  assign fifo_empty = (wp == rp);
  assign fifo_full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rsp_rd     = ~fifo_empty & mcif2bdma_rd_rsp_ready;

`ifdef SA_AUTOSA_RD_LAT_FIFO_OVF_CHECK_EN
  logic wr_drop;
  assign wr_drop = mem_rd_rsp_valid & fifo_full & ~rsp_rd;
  assign rsp_wr  = mem_rd_rsp_valid & ~wr_drop;
  assign rp_step = rsp_rd;
`else
  logic wr_over;
  // Overwriting a full FIFO replaces the oldest atom, so the head moves with it
  assign wr_over = mem_rd_rsp_valid & fifo_full & ~rsp_rd;
  assign rsp_wr  = mem_rd_rsp_valid;
  assign rp_step = rsp_rd | wr_over;
`endif

  assign wp_nxt         = wp + {{AW{1'b0}}, rsp_wr};
  assign rp_nxt         = rp + {{AW{1'b0}}, rp_step};
  assign fifo_empty_nxt = (wp_nxt == rp_nxt);

  assign mcif2bdma_rd_rsp_valid = ~fifo_empty;
  assign mcif2bdma_rd_rsp_pd    = mem[rp[AW-1:0]];

  // Data array: no reset needed, the pointers define which entries are live
  always_ff @(posedge autosa_core_clk) begin
    if (rsp_wr) begin
      mem[wp[AW-1:0]] <= mem_rd_rsp_pd;
    end
  end

  // Pointers, credits and registered status derived from next-state values
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      wp        <= '0;
      rp        <= '0;
      cdt_used  <= '0;
      cdt_avail <= DEPTH_CW;
      rd_idle   <= 1'b1;
    end else begin
      wp        <= wp_nxt;
      rp        <= rp_nxt;
      cdt_used  <= cdt_used_nxt;
      cdt_avail <= DEPTH_CW - cdt_used_nxt;
      rd_idle   <= (cdt_used_nxt == '0) & fifo_empty_nxt;
    end
  end

  // Sticky flag for requests that can never fit in the FIFO
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      size_err <= 1'b0;
    end else if (bdma2mcif_rd_req_valid && (req_need > DEPTH16)) begin
      size_err <= 1'b1;
    end
  end

`ifdef SA_AUTOSA_RD_LAT_FIFO_OVF_CHECK_EN
  // Sticky flag for an atom dropped because the FIFO was full
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      rsp_ovf <= 1'b0;
    end else if (wr_drop) begin
      rsp_ovf <= 1'b1;
    end
  end
`else
  assign rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sa_autosa_bdma_rd_lat_fifo.sv
// tb/tb_sa_autosa_bdma_rd_lat_fifo.sv - self-checking bench for sa_autosa_bdma_rd_lat_fifo
module tb_sa_autosa_bdma_rd_lat_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CW    = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [78:0]    req_pd;
  logic           m_req_valid;
  logic           m_req_ready;
  logic [78:0]    m_req_pd;
  logic           rsp_in_valid;
  logic [513:0]   rsp_in_pd;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [513:0]   rsp_pd;
  logic           pop;
  logic [CW-1:0]  cdt_avail;
  logic           rd_idle;
  logic           size_err;
  logic           rsp_ovf;

  int nchk  = 0;
  int nfail = 0;

  // Reference model state
  int           m_used;
  logic [513:0] m_q[$];
  bit           m_serr;
  bit           m_ovf;

  always #5 clk = ~clk;

  sa_autosa_bdma_rd_lat_fifo #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .autosa_core_clk               (clk),
    .autosa_core_rstn              (rst_n),
    .bdma2mcif_rd_req_valid        (req_valid),
    .bdma2mcif_rd_req_ready        (req_ready),
    .bdma2mcif_rd_req_pd           (req_pd),
    .mem_rd_req_valid              (m_req_valid),
    .mem_rd_req_ready              (m_req_ready),
    .mem_rd_req_pd                 (m_req_pd),
    .mem_rd_rsp_valid              (rsp_in_valid),
    .mem_rd_rsp_pd                 (rsp_in_pd),
    .mcif2bdma_rd_rsp_valid        (rsp_valid),
    .mcif2bdma_rd_rsp_ready        (rsp_ready),
    .mcif2bdma_rd_rsp_pd           (rsp_pd),
    .bdma2mcif_rd_cdt_lat_fifo_pop (pop),
    .cdt_avail                     (cdt_avail),
    .rd_idle                       (rd_idle),
    .size_err                      (size_err),
    .rsp_ovf                       (rsp_ovf)
  );

  function automatic logic [513:0] rand_atom();
    logic [543:0] t;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    return t[513:0];
  endfunction

  function automatic bit m_fit();
    return (int'(req_pd[78:64]) + 1) <= (DEPTH - m_used);
  endfunction

  task automatic drive(input bit rv, input int sz, input bit mr, input bit wv,
                       input logic [513:0] wd, input bit rr, input bit pp);
    req_valid    = rv;
    req_pd       = {15'(sz), $urandom, $urandom};
    m_req_ready  = mr;
    rsp_in_valid = wv;
    rsp_in_pd    = wd;
    rsp_ready    = rr;
    pop          = pp;
  endtask

  // Apply the current inputs to the model, then advance one clock
  task automatic step();
    int  need;
    bit  acc;
    bit  rd;
    need = int'(req_pd[78:64]) + 1;
    acc  = req_valid && m_req_ready && m_fit();
    if (req_valid && need > DEPTH) m_serr = 1'b1;
    if (pop && m_used > 0) m_used--;
    if (acc) m_used += need;
    rd = (m_q.size() > 0) && rsp_ready;
    if (rd) void'(m_q.pop_front());
    if (rsp_in_valid) begin
      if (m_q.size() == DEPTH) begin
`ifdef SA_AUTOSA_RD_LAT_FIFO_OVF_CHECK_EN
        m_ovf = 1'b1;
`else
        void'(m_q.pop_front());
        m_q.push_back(rsp_in_pd);
`endif
      end else begin
        m_q.push_back(rsp_in_pd);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, '0, 0, 0);
    m_used = 0;
    m_q.delete();
    m_serr = 1'b0;
    m_ovf  = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    assert_reset();
    nchk++; if (rsp_valid !== 1'b0) begin nfail++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
    nchk++; if (cdt_avail !== 3'(DEPTH)) begin nfail++; $display("FAIL reset_cdt_avail got=%0d want=%0d", cdt_avail, DEPTH); end
    nchk++; if (rd_idle !== 1'b1) begin nfail++; $display("FAIL reset_rd_idle got=%0b want=1", rd_idle); end
    nchk++; if (size_err !== 1'b0) begin nfail++; $display("FAIL reset_size_err got=%0b want=0", size_err); end
    nchk++; if (rsp_ovf !== 1'b0) begin nfail++; $display("FAIL reset_rsp_ovf got=%0b want=0", rsp_ovf); end
    release_reset();
  endtask

  task automatic test_credit();
    drive(1, 3, 1, 0, '0, 0, 0); #1;
    nchk++; if (req_ready !== 1'b1) begin nfail++; $display("FAIL credit_n4_ready got=%0b want=1", req_ready); end
    nchk++; if (m_req_valid !== 1'b1) begin nfail++; $display("FAIL credit_n4_fwd got=%0b want=1", m_req_valid); end
    step();
    nchk++; if (cdt_avail !== 3'd0) begin nfail++; $display("FAIL credit_avail_after_n4 got=%0d want=0", cdt_avail); end
    drive(1, 0, 1, 0, '0, 0, 0); #1;
    nchk++; if (req_ready !== 1'b0 || m_req_valid !== 1'b0) begin nfail++; $display("FAIL credit_hold got=%0b/%0b want=0/0", req_ready, m_req_valid); end
    step();
    nchk++; if (req_ready !== 1'b0) begin nfail++; $display("FAIL credit_still_held got=%0b want=0", req_ready); end
    pop = 1'b1; #1;
    nchk++; if (req_ready !== 1'b0) begin nfail++; $display("FAIL credit_pop_cycle got=%0b want=0", req_ready); end
    step();
    pop = 1'b0; #1;
    nchk++; if (req_ready !== 1'b1 || m_req_valid !== 1'b1) begin nfail++; $display("FAIL credit_after_pop got=%0b/%0b want=1/1", req_ready, m_req_valid); end
    step();
    nchk++; if (cdt_avail !== 3'd0) begin nfail++; $display("FAIL credit_avail_final got=%0d want=0", cdt_avail); end
  endtask

  task automatic test_rsp_order();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 514'(10 + i), 1, 0);
      step();
      nchk++; if (rsp_valid !== 1'b1 || rsp_pd !== 514'(10 + i)) begin nfail++; $display("FAIL order_out%0d got=%0b/%0h want=1/%0h", i, rsp_valid, rsp_pd, 10 + i); end
    end
    drive(0, 0, 0, 0, '0, 1, 0);
    step();
    nchk++; if (rsp_valid !== 1'b0) begin nfail++; $display("FAIL order_empty got=%0b want=0", rsp_valid); end
    for (int k = 0; k < 4; k++) begin
      nchk++; if (rd_idle !== 1'b0) begin nfail++; $display("FAIL order_idle_early%0d got=%0b want=0", k, rd_idle); end
      drive(0, 0, 0, 0, '0, 1, 1);
      step();
    end
    nchk++; if (rd_idle !== 1'b1) begin nfail++; $display("FAIL order_idle_after_pops got=%0b want=1", rd_idle); end
  endtask

  task automatic test_fill_read();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 514'(32'h100 + i), 0, 0);
      step();
      nchk++; if (rsp_pd !== 514'(32'h100)) begin nfail++; $display("FAIL fill_head%0d got=%0h want=100", i, rsp_pd); end
    end
    drive(0, 0, 0, 1, 514'(32'h104), 1, 0);
    step();
    nchk++; if (rsp_ovf !== 1'b0) begin nfail++; $display("FAIL fill_ovf got=%0b want=0", rsp_ovf); end
    for (int k = 0; k < 4; k++) begin
      nchk++; if (rsp_valid !== 1'b1 || rsp_pd !== 514'(32'h101 + k)) begin nfail++; $display("FAIL fill_drain%0d got=%0b/%0h want=1/%0h", k, rsp_valid, rsp_pd, 32'h101 + k); end
      drive(0, 0, 0, 0, '0, 1, 0);
      step();
    end
    nchk++; if (rsp_valid !== 1'b0) begin nfail++; $display("FAIL fill_empty got=%0b want=0", rsp_valid); end
  endtask

  task automatic test_acc_pop();
    assert_reset();
    release_reset();
    drive(1, 0, 1, 0, '0, 0, 0);
    step();
    drive(1, 1, 1, 0, '0, 0, 1); #1;
    nchk++; if (req_ready !== 1'b1) begin nfail++; $display("FAIL accpop_ready got=%0b want=1", req_ready); end
    step();
    nchk++; if (cdt_avail !== 3'd2) begin nfail++; $display("FAIL accpop_avail got=%0d want=2", cdt_avail); end
  endtask

  task automatic test_size_err();
    drive(1, 4, 1, 0, '0, 0, 0); #1;
    nchk++; if (m_req_valid !== 1'b0 || req_ready !== 1'b0) begin nfail++; $display("FAIL serr_fwd got=%0b/%0b want=0/0", m_req_valid, req_ready); end
    step();
    nchk++; if (size_err !== 1'b1) begin nfail++; $display("FAIL serr_set got=%0b want=1", size_err); end
    drive(0, 0, 0, 0, '0, 0, 0);
    repeat (3) step();
    nchk++; if (size_err !== 1'b1) begin nfail++; $display("FAIL serr_sticky got=%0b want=1", size_err); end
    assert_reset();
    nchk++; if (size_err !== 1'b0 || cdt_avail !== 3'(DEPTH)) begin nfail++; $display("FAIL serr_reset got=%0b/%0d want=0/%0d", size_err, cdt_avail, DEPTH); end
    release_reset();
  endtask

`ifdef SA_AUTOSA_RD_LAT_FIFO_OVF_CHECK_EN
  task automatic test_ovf();
    assert_reset();
    release_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 514'(32'h200 + i), 0, 0);
      step();
    end
    nchk++; if (rsp_ovf !== 1'b1) begin nfail++; $display("FAIL ovf_flag got=%0b want=1", rsp_ovf); end
    nchk++; if (rsp_pd !== 514'(32'h200)) begin nfail++; $display("FAIL ovf_head got=%0h want=200", rsp_pd); end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, '0, 1, 0);
      step();
    end
    nchk++; if (rsp_valid !== 1'b0) begin nfail++; $display("FAIL ovf_dropped got=%0b want=0", rsp_valid); end
  endtask
`endif

  task automatic test_random();
    bit rv, mr, rr, pp, wv;
    int sz;
    assert_reset();
    release_reset();
    for (int c = 0; c < 400; c++) begin
      rv = $urandom_range(0, 1);
      sz = $urandom_range(0, 3);
      mr = ($urandom_range(0, 3) != 0);
      rr = $urandom_range(0, 1);
      pp = ($urandom_range(0, 2) == 0);
      wv = $urandom_range(0, 1) && ((m_q.size() < DEPTH) || rr);
      drive(rv, sz, mr, wv, rand_atom(), rr, pp); #1;
      nchk++; if (m_req_valid !== (rv && m_fit()) || req_ready !== (mr && m_fit())) begin nfail++; $display("FAIL rnd_req c=%0d got=%0b/%0b want=%0b/%0b", c, m_req_valid, req_ready, rv && m_fit(), mr && m_fit()); end
      nchk++; if (m_req_pd !== req_pd) begin nfail++; $display("FAIL rnd_pd c=%0d got=%0h want=%0h", c, m_req_pd, req_pd); end
      step();
      nchk++; if (cdt_avail !== 3'(DEPTH - m_used)) begin nfail++; $display("FAIL rnd_avail c=%0d got=%0d want=%0d", c, cdt_avail, DEPTH - m_used); end
      nchk++; if (rd_idle !== (m_used == 0 && m_q.size() == 0)) begin nfail++; $display("FAIL rnd_idle c=%0d got=%0b", c, rd_idle); end
      nchk++; if (rsp_valid !== (m_q.size() != 0)) begin nfail++; $display("FAIL rnd_valid c=%0d got=%0b want=%0b", c, rsp_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        nchk++; if (rsp_pd !== m_q[0]) begin nfail++; $display("FAIL rnd_data c=%0d got=%0h want=%0h", c, rsp_pd, m_q[0]); end
      end
      nchk++; if (size_err !== m_serr || rsp_ovf !== m_ovf) begin nfail++; $display("FAIL rnd_flags c=%0d got=%0b/%0b want=%0b/%0b", c, size_err, rsp_ovf, m_serr, m_ovf); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 1, 1, 514'(32'h300), 0, 0);
    step();
    drive(0, 0, 0, 1, 514'(32'h301), 0, 0);
    step();
    nchk++; if (rsp_valid !== 1'b1) begin nfail++; $display("FAIL mid_pre_valid got=%0b want=1", rsp_valid); end
    #2;
    assert_reset();
    nchk++; if (rsp_valid !== 1'b0 || rd_idle !== 1'b1 || cdt_avail !== 3'(DEPTH)) begin nfail++; $display("FAIL mid_async got=%0b/%0b/%0d want=0/1/%0d", rsp_valid, rd_idle, cdt_avail, DEPTH); end
    release_reset();
    nchk++; if (rsp_valid !== 1'b0 || cdt_avail !== 3'(DEPTH)) begin nfail++; $display("FAIL mid_after got=%0b/%0d want=0/%0d", rsp_valid, cdt_avail, DEPTH); end
  endtask

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 0, 0, '0, 0, 0);
    #2;
    test_reset();
    test_credit();
    test_rsp_order();
    test_fill_read();
    test_acc_pop();
    test_size_err();
`ifdef SA_AUTOSA_RD_LAT_FIFO_OVF_CHECK_EN
    test_ovf();
`endif
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/sa_autosa_bdma_rd_lat_fifo.md
Name: sa_autosa_bdma_rd_lat_fifo

Overview:
Memory-side read-return stage between the BDMA engine and the memory interface (MCIF) read port.
- Forwards BDMA read requests to memory only when enough latency-FIFO credits exist.
- Buffers the memory read responses, which arrive without backpressure, and presents them to BDMA on a valid/ready interface.
- Returns credits when BDMA pulses its rd_cdt_lat_fifo_pop output.

Parameters:
DEPTH, 32, response FIFO entries (64B atoms); power of two, 4..256
AW, 5, log2(DEPTH)
CW, 6, credit counter width = AW+1

Ports:
autosa_core_clk  in  1  clock
autosa_core_rstn  in  1  asynchronous active-low reset
bdma2mcif_rd_req_valid  in  1  BDMA read request valid
bdma2mcif_rd_req_ready  out  1  request accepted
bdma2mcif_rd_req_pd  in  79  [63:0] addr, [78:64] size (atoms-1)
mem_rd_req_valid  out  1  request to memory
mem_rd_req_ready  in  1  memory accepts request
mem_rd_req_pd  out  79  pass-through of bdma2mcif_rd_req_pd
mem_rd_rsp_valid  in  1  response atom from memory, no backpressure
mem_rd_rsp_pd  in  514  response atom
mcif2bdma_rd_rsp_valid  out  1  buffered response valid
mcif2bdma_rd_rsp_ready  in  1  BDMA accepts response
mcif2bdma_rd_rsp_pd  out  514  buffered response
bdma2mcif_rd_cdt_lat_fifo_pop  in  1  return one credit
cdt_avail  out  CW  free credits
rd_idle  out  1  no credits in use and FIFO empty
size_err  out  1  sticky: request needs more than DEPTH atoms
rsp_ovf  out  1  sticky FIFO overflow (see Optional Feature)

Behaviour:
- Clock and reset: one clock, autosa_core_clk. Reset autosa_core_rstn is asynchronous, active-low, and clears all state.
- Reset values: cdt_used=0, FIFO empty, mcif2bdma_rd_rsp_valid=0, cdt_avail=DEPTH, rd_idle=1, size_err=0, rsp_ovf=0.
- Request need: n = size+1, computed 16 bits wide with no truncation.
- Request path is combinational pass-through:
  - mem_rd_req_valid = req_valid & (n <= DEPTH-cdt_used).
  - bdma2mcif_rd_req_ready = mem_rd_req_ready & (n <= DEPTH-cdt_used).
  - pd passes straight through.
  - A request that does not fit is held, not dropped, and not forwarded.
- Credit counter update per cycle: cdt_used_next = cdt_used + (acc ? n : 0) - (pop ? 1 : 0).
  - acc = req valid & ready.
  - A simultaneous accept and pop are both applied in the same cycle.
  - A pop when cdt_used==0 is ignored; the counter saturates at 0.
- cdt_avail = DEPTH-cdt_used, registered value.
- size_err: set when req_valid and n>DEPTH. The request stalls forever; recovery is by reset only.
- Response FIFO: register array with write pointer wp and read pointer rp, each AW+1 bits including a wrap bit.
  - A write occurs every cycle mem_rd_rsp_valid=1.
  - Full: pointer MSBs differ and low bits are equal. Empty: pointers are equal.
- Response output:
  - mcif2bdma_rd_rsp_valid = !empty; pd = mem[rp].
  - An atom written in cycle N becomes visible in cycle N+1, so latency is 1 cycle.
  - rp advances on valid&ready.
  - A write and a read in the same cycle are both applied; count is unchanged.
  - Write into a full FIFO while a read happens in the same cycle is legal.
- Pointer wrap: pointers wrap modulo 2*DEPTH.
- rd_idle = (cdt_used==0) & empty, registered.
- Reset mid-transfer: all in-flight credits and buffered data are discarded. No outputs glitch after the reset edge; valid outputs go low asynchronously.

Optional Feature:
- Macro: SA_AUTOSA_RD_LAT_FIFO_OVF_CHECK_EN.
- When defined: a write into a full FIFO with no read in the same cycle drops the atom and sets sticky rsp_ovf. rsp_ovf is cleared only by reset. Pointers are unchanged by the dropped write.
- When not defined: rsp_ovf is tied to 0 and no full check is applied on writes, so an overflow overwrites the oldest entry. This is allowed because the credit protocol guarantees overflow cannot occur.

Test Plan:
1. DEPTH=4. Request size=3 (n=4), mem ready -> accepted in 1 cycle; cdt_avail 4->0; a second request size=0 is held with ready=0 until one pop, then accepted; cdt_avail reads 0.
2. 4 responses 0xA..0xD on consecutive cycles with rsp_ready=1 -> outputs 0xA..0xD on cycles N+1..N+4, in order; FIFO empty after; rd_idle=1 only after 4 pops.
3. Fill FIFO (4 atoms) with rsp_ready=0, then ready=1 while a 5th response arrives in the same cycle as a read -> no loss, order preserved, rsp_ovf=0.
4. Accept n=2 and pop in the same cycle, starting from cdt_used=1 -> cdt_used=2 (cdt_avail=2).
5. Request size=4 with DEPTH=4 -> size_err=1, never forwarded; assert reset -> size_err=0, cdt_avail=4.
6. With OVF_CHECK_EN: force a 5th write while full with no read -> rsp_ovf=1, head data unchanged.
